// File: rtl/audio_pkg.sv
// Shared audio definitions: sound codes, arbiter state encoding and the
// pending-flag bundle used by the sound arbiter.
package audio_pkg;

    localparam int unsigned SND_W  = 2;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned DROP_W = 8;

    typedef enum logic [SND_W-1:0] {
        SND_NONE   = 2'd0,
        SND_MISS   = 2'd1,
        SND_BOUNCE = 2'd2,
        SND_HIT    = 2'd3
    } snd_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_HOLD  = 2'd2
    } arb_state_e;

    // One sticky flag per sound
    typedef struct packed {
        logic miss;
        logic bounce;
        logic hit;
    } snd_flags_t;

    // Fixed priority: miss > hit > bounce
    function automatic snd_e pick_sound(input snd_flags_t f);
        snd_e s;
        if (f.miss) begin
            s = SND_MISS;
        end else if (f.hit) begin
            s = SND_HIT;
        end else if (f.bounce) begin
            s = SND_BOUNCE;
        end else begin
            s = SND_NONE;
        end
        return s;
    endfunction

    // A zero guard time behaves as one millisecond
    function automatic logic [HOLD_W-1:0] hold_clamp(input logic [HOLD_W-1:0] ms);
        return (ms == '0) ? HOLD_W'(1) : ms;
    endfunction

endpackage

// File: rtl/audio_sound_arbiter_if.sv
// Game-logic <-> sound arbiter bundle.
// Optional drop counter signal present when AUDIO_ARB_DROPCNT_EN is defined.
interface audio_sound_arbiter_if;

    logic       en;
    logic       req_miss;
    logic       req_bounce;
    logic       req_hit;
    logic [1:0] snd_sel;
    logic       busy;
`ifdef AUDIO_ARB_DROPCNT_EN
    logic [audio_pkg::DROP_W-1:0] drop_cnt;

    modport master (output en, req_miss, req_bounce, req_hit,
                    input  snd_sel, busy, drop_cnt);
    modport slave  (input  en, req_miss, req_bounce, req_hit,
                    output snd_sel, busy, drop_cnt);
`else
    modport master (output en, req_miss, req_bounce, req_hit,
                    input  snd_sel, busy);
    modport slave  (input  en, req_miss, req_bounce, req_hit,
                    output snd_sel, busy);
`endif

endinterface

// File: rtl/audio_ms_tick.sv
// Millisecond prescaler: counts 0..CLKS_PER_MS-1 and raises a registered
// one-cycle tick while the count sits at its terminal value.
module audio_ms_tick #(
    parameter int unsigned CLKS_PER_MS = 16000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_MS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;

    // Wrap at terminal count
    always_comb begin
        cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
    end

    // Counter and tick registers; restart forces count 0 with no tick
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == TERM);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/audio_sound_arbiter.sv
// Sound arbiter: collects one-shot sound requests as sticky pending flags,
// issues them one at a time by fixed priority and enforces a per-sound
// guard time before the next issue.
// Optional drop counter enabled by macro AUDIO_ARB_DROPCNT_EN.
module audio_sound_arbiter
    import audio_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS    = 16000,
    parameter int unsigned HOLD_MS_MISS   = 70,
    parameter int unsigned HOLD_MS_BOUNCE = 50,
    parameter int unsigned HOLD_MS_HIT    = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    audio_sound_arbiter_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_MISS   = hold_clamp(HOLD_W'(HOLD_MS_MISS));
    localparam logic [HOLD_W-1:0] HOLD_BOUNCE = hold_clamp(HOLD_W'(HOLD_MS_BOUNCE));
    localparam logic [HOLD_W-1:0] HOLD_HIT    = hold_clamp(HOLD_W'(HOLD_MS_HIT));

    arb_state_e        state_q;
    snd_e              code_q;
    snd_e              snd_sel_q;
    snd_flags_t        pend_q;
    snd_flags_t        pend_d;
    snd_flags_t        req_c;
    logic [HOLD_W-1:0] hold_q;
    logic              busy_q;
    logic              ms_tick;
    logic              restart_c;
    logic              start_c;
    snd_e              pick_c;

    function automatic logic [HOLD_W-1:0] hold_load(input snd_e code);
        logic [HOLD_W-1:0] ms;
        case (code)
            SND_MISS:   ms = HOLD_MISS;
            SND_BOUNCE: ms = HOLD_BOUNCE;
            default:    ms = HOLD_HIT;
        endcase
        return ms;
    endfunction

    // Pending flags: en low flushes everything, otherwise requests are OR-ed
    // in and the sound being issued is cleared last so a same-cycle repeat loses
    always_comb begin
        req_c.miss   = bus.req_miss;
        req_c.bounce = bus.req_bounce;
        req_c.hit    = bus.req_hit;
        pend_d       = pend_q;
        if (!bus.en) begin
            pend_d = '0;
        end else begin
            pend_d = snd_flags_t'(pend_q | req_c);
            if (state_q == ARB_ISSUE) begin
                case (code_q)
                    SND_MISS:   pend_d.miss   = 1'b0;
                    SND_BOUNCE: pend_d.bounce = 1'b0;
                    SND_HIT:    pend_d.hit    = 1'b0;
                    default:    ;
                endcase
            end
        end
    end

    assign start_c   = (state_q == ARB_IDLE) && bus.en && (pend_q != '0);
    assign pick_c    = pick_sound(pend_q);
    assign restart_c = (state_q == ARB_ISSUE);

    audio_ms_tick #(
        .CLKS_PER_MS (CLKS_PER_MS)
    ) u_ms_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_c),
        .tick    (ms_tick)
    );

    // Arbiter FSM with registered snd_sel/busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            code_q    <= SND_NONE;
            snd_sel_q <= SND_NONE;
            pend_q    <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            snd_sel_q <= SND_NONE;
            busy_q    <= (pend_d != '0);
            case (state_q)
                ARB_IDLE: begin
                    if (start_c) begin
                        state_q   <= ARB_ISSUE;
                        code_q    <= pick_c;
                        snd_sel_q <= pick_c;
                        busy_q    <= 1'b1;
                    end
                end
                ARB_ISSUE: begin
                    state_q <= ARB_HOLD;
                    hold_q  <= hold_load(code_q);
                    busy_q  <= 1'b1;
                end
                ARB_HOLD: begin
                    if (ms_tick) begin
                        hold_q <= hold_q - HOLD_W'(1);
                        if (hold_q == HOLD_W'(1)) begin
                            state_q <= ARB_IDLE;
                        end else begin
                            busy_q <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.snd_sel = snd_sel_q;
    assign bus.busy    = busy_q;

`ifdef AUDIO_ARB_DROPCNT_EN
    logic              drop_c;
    logic [DROP_W-1:0] drop_q;

    // A cycle counts as a drop if any request is a duplicate or is discarded by en
    assign drop_c = bus.en ? ((pend_q & req_c) != 3'b000) : (req_c != 3'b000);

    // Saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop_c && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end

    assign bus.drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_audio_sound_arbiter.sv
// Self-checking bench for audio_sound_arbiter (CLKS_PER_MS=4, holds 3/2/1 ms).
// Drop counter checks compile in when AUDIO_ARB_DROPCNT_EN is defined.
module tb_audio_sound_arbiter;

    localparam int CPM = 4;
    localparam int HMS_MISS = 3;
    localparam int HMS_BOUNCE = 2;
    localparam int HMS_HIT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    audio_sound_arbiter_if bus();

    audio_sound_arbiter #(
        .CLKS_PER_MS    (CPM),
        .HOLD_MS_MISS   (HMS_MISS),
        .HOLD_MS_BOUNCE (HMS_BOUNCE),
        .HOLD_MS_HIT    (HMS_HIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: time-scheduled view. Codes 1=miss 2=bounce 3=hit.
    int         mc = 0;
    bit         m_pend [1:3];
    int         m_idle_from = 0;
    int         m_iss_at = -1;
    int         m_iss_code = 0;
    int         m_drop = 0;
    logic [1:0] exp_sel = 2'd0;
    logic       exp_busy = 1'b0;

    function automatic int hold_cycles(input int code);
        int ms;
        ms = (code == 1) ? HMS_MISS : (code == 2) ? HMS_BOUNCE : HMS_HIT;
        if (ms == 0) ms = 1;
        return ms * CPM;
    endfunction

    // Advance the model by the cycle whose inputs are sampled at this edge
    task automatic model_step();
        bit r [1:3];
        bit pn [1:3];
        bit any_drop;
        bit any_pend;
        int k;
        r[1] = bus.req_miss;
        r[2] = bus.req_bounce;
        r[3] = bus.req_hit;
        if (rst) begin
            for (int i = 1; i <= 3; i++) m_pend[i] = 1'b0;
            m_idle_from = mc + 1;
            m_iss_at = -1;
            m_drop = 0;
            exp_sel = 2'd0;
            exp_busy = 1'b0;
        end else begin
            any_drop = 1'b0;
            for (int i = 1; i <= 3; i++)
                if (r[i] && (!bus.en || m_pend[i])) any_drop = 1'b1;
            if (any_drop && m_drop < 255) m_drop++;
            if (mc >= m_idle_from && bus.en && (m_pend[1] || m_pend[2] || m_pend[3])) begin
                k = m_pend[1] ? 1 : (m_pend[3] ? 3 : 2);
                m_iss_at = mc + 1;
                m_iss_code = k;
                m_idle_from = mc + 2 + hold_cycles(k);
            end
            for (int i = 1; i <= 3; i++) pn[i] = bus.en && (m_pend[i] || r[i]);
            if (m_iss_at == mc) pn[m_iss_code] = 1'b0;
            any_pend = 1'b0;
            for (int i = 1; i <= 3; i++) begin
                m_pend[i] = pn[i];
                any_pend = any_pend | pn[i];
            end
            exp_sel = (m_iss_at == mc + 1) ? 2'(m_iss_code) : 2'd0;
            exp_busy = (mc + 1 < m_idle_from) || any_pend;
        end
        mc++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_reqs();
        bus.req_miss = 1'b0;
        bus.req_bounce = 1'b0;
        bus.req_hit = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        clear_reqs();
        while (bus.busy === 1'b1 && n < 200) begin
            next_cycle();
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout busy=%b required 0", name, bus.busy);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1;
        clear_reqs();
        bus.req_miss = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            checks++;
            if (bus.snd_sel !== 2'd0) begin
                errors++;
                $display("FAIL reset_sel k=%0d got %0d required 0", k, bus.snd_sel);
            end
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy k=%0d got %b required 0", k, bus.busy);
            end
        end
        rst = 1'b0;
        clear_reqs();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            checks++;
            if (bus.snd_sel !== 2'd0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset k=%0d sel=%0d busy=%b required 0/0", k, bus.snd_sel, bus.busy);
            end
        end
`ifdef AUDIO_ARB_DROPCNT_EN
        checks++;
        if (bus.drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop got %0d required 0", bus.drop_cnt);
        end
`endif
    endtask

    task automatic test_single();
        logic [1:0] es;
        logic       eb;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) begin
                next_cycle();
                es = (k == 2) ? 2'd2 : 2'd0;
                eb = (k <= 10);
                checks++;
                if (bus.snd_sel !== es) begin
                    errors++;
                    $display("FAIL single_sel k=%0d got %0d required %0d", k, bus.snd_sel, es);
                end
                checks++;
                if (bus.busy !== eb) begin
                    errors++;
                    $display("FAIL single_busy k=%0d got %b required %b", k, bus.busy, eb);
                end
            end
            clear_reqs();
            if (k == 0) bus.req_bounce = 1'b1;
        end
        wait_idle("single");
    endtask

    task automatic test_priority();
        int ev_cyc[$];
        int ev_code[$];
        int exp_c[3] = '{2, 16, 22};
        int exp_s[3] = '{1, 3, 2};
        int gc, gs;
`ifdef AUDIO_ARB_DROPCNT_EN
        int d0 = int'(bus.drop_cnt);
`endif
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                next_cycle();
                if (bus.snd_sel !== 2'd0) begin
                    ev_cyc.push_back(k);
                    ev_code.push_back(int'(bus.snd_sel));
                end
            end
            clear_reqs();
            if (k == 0) begin
                bus.req_miss = 1'b1;
                bus.req_bounce = 1'b1;
                bus.req_hit = 1'b1;
            end
        end
        checks++;
        if (ev_cyc.size() != 3) begin
            errors++;
            $display("FAIL prio_count got %0d issues required 3", ev_cyc.size());
        end
        for (int i = 0; i < 3; i++) begin
            gc = (i < ev_cyc.size()) ? ev_cyc[i] : -1;
            gs = (i < ev_code.size()) ? ev_code[i] : -1;
            checks++;
            if (gc != exp_c[i] || gs != exp_s[i]) begin
                errors++;
                $display("FAIL prio_issue%0d got code %0d at k=%0d required code %0d at k=%0d",
                         i, gs, gc, exp_s[i], exp_c[i]);
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL prio_end_busy got %b required 0", bus.busy);
        end
`ifdef AUDIO_ARB_DROPCNT_EN
        checks++;
        if (int'(bus.drop_cnt) - d0 != 0) begin
            errors++;
            $display("FAIL prio_drop delta %0d required 0", int'(bus.drop_cnt) - d0);
        end
`endif
        wait_idle("prio");
    endtask

    // Miss issued at k=2; second-sound pulses at p1 and p2 (one may collide)
    task automatic run_two_sound(input string name, input int p1, input bit p1_miss,
                                 input int p2, input int exp_drop);
        int ev_cyc[$];
        int ev_code[$];
        int gc, gs;
        int exp_c[2] = '{2, 16};
        int exp_s[2] = '{1, 3};
`ifdef AUDIO_ARB_DROPCNT_EN
        int d0 = int'(bus.drop_cnt);
`endif
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                next_cycle();
                if (bus.snd_sel !== 2'd0) begin
                    ev_cyc.push_back(k);
                    ev_code.push_back(int'(bus.snd_sel));
                end
            end
            clear_reqs();
            if (k == 0) bus.req_miss = 1'b1;
            if (k == p1) begin
                bus.req_hit = 1'b1;
                bus.req_miss = p1_miss;
            end
            if (k == p2) bus.req_hit = 1'b1;
        end
        checks++;
        if (ev_cyc.size() != 2) begin
            errors++;
            $display("FAIL %s_count got %0d issues required 2", name, ev_cyc.size());
        end
        for (int i = 0; i < 2; i++) begin
            gc = (i < ev_cyc.size()) ? ev_cyc[i] : -1;
            gs = (i < ev_code.size()) ? ev_code[i] : -1;
            checks++;
            if (gc != exp_c[i] || gs != exp_s[i]) begin
                errors++;
                $display("FAIL %s_issue%0d got code %0d at k=%0d required code %0d at k=%0d",
                         name, i, gs, gc, exp_s[i], exp_c[i]);
            end
        end
`ifdef AUDIO_ARB_DROPCNT_EN
        checks++;
        if (int'(bus.drop_cnt) - d0 != exp_drop) begin
            errors++;
            $display("FAIL %s_drop delta %0d required %0d", name, int'(bus.drop_cnt) - d0, exp_drop);
        end
`else
        if (exp_drop < 0) $display("unexpected drop argument");
`endif
        wait_idle(name);
    endtask

    task automatic test_dup_drop();
        run_two_sound("dup", 5, 1'b0, 8, 1);
    endtask

    task automatic test_collision();
        run_two_sound("collide", 2, 1'b1, -1, 1);
    endtask

    task automatic test_reset_mid_hold();
        logic [1:0] es;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) begin
                next_cycle();
                if (k == 2 || k >= 8) begin
                    es = (k == 2) ? 2'd1 : (k == 12) ? 2'd3 : 2'd0;
                    checks++;
                    if (bus.snd_sel !== es) begin
                        errors++;
                        $display("FAIL rsthold_sel k=%0d got %0d required %0d", k, bus.snd_sel, es);
                    end
                end
                if (k == 8 || k == 9 || k == 11) begin
                    checks++;
                    if (bus.busy !== (k == 11)) begin
                        errors++;
                        $display("FAIL rsthold_busy k=%0d got %b required %b", k, bus.busy, (k == 11));
                    end
                end
`ifdef AUDIO_ARB_DROPCNT_EN
                if (k == 8) begin
                    checks++;
                    if (bus.drop_cnt !== 8'd0) begin
                        errors++;
                        $display("FAIL rsthold_drop got %0d required 0", bus.drop_cnt);
                    end
                end
`endif
            end
            clear_reqs();
            rst = (k == 7);
            if (k == 0) bus.req_miss = 1'b1;
            if (k == 4) bus.req_bounce = 1'b1;
            if (k == 7 || k == 10) bus.req_hit = 1'b1;
        end
        rst = 1'b0;
        wait_idle("rsthold");
    endtask

    task automatic test_enable();
        int n_iss = 0;
`ifdef AUDIO_ARB_DROPCNT_EN
        int d0 = int'(bus.drop_cnt);
`endif
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) begin
                next_cycle();
                if (bus.snd_sel !== 2'd0) begin
                    n_iss++;
                    checks++;
                    if (k != 2 || bus.snd_sel !== 2'd1) begin
                        errors++;
                        $display("FAIL enable_sel k=%0d got %0d required 0", k, bus.snd_sel);
                    end
                end
                if (k == 14 || k == 15 || k == 30) begin
                    checks++;
                    if (bus.busy !== (k == 14)) begin
                        errors++;
                        $display("FAIL enable_busy k=%0d got %b required %b", k, bus.busy, (k == 14));
                    end
                end
            end
            clear_reqs();
            bus.en = !(k >= 8 && k < 25);
            if (k == 0) bus.req_miss = 1'b1;
            if (k == 4 || k == 10) bus.req_bounce = 1'b1;
            if (k == 5 || k == 12) bus.req_hit = 1'b1;
        end
        checks++;
        if (n_iss != 1) begin
            errors++;
            $display("FAIL enable_issue_count got %0d required 1", n_iss);
        end
`ifdef AUDIO_ARB_DROPCNT_EN
        checks++;
        if (int'(bus.drop_cnt) - d0 != 2) begin
            errors++;
            $display("FAIL enable_drop delta %0d required 2", int'(bus.drop_cnt) - d0);
        end
`endif
        bus.en = 1'b1;
        wait_idle("enable");
    endtask

    task automatic test_random();
        bit en_r = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            next_cycle();
            checks++;
            if (bus.snd_sel !== exp_sel) begin
                errors++;
                $display("FAIL rand_sel n=%0d got %0d required %0d", n, bus.snd_sel, exp_sel);
            end
            checks++;
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL rand_busy n=%0d got %b required %b", n, bus.busy, exp_busy);
            end
`ifdef AUDIO_ARB_DROPCNT_EN
            checks++;
            if (bus.drop_cnt !== 8'(m_drop)) begin
                errors++;
                $display("FAIL rand_drop n=%0d got %0d required %0d", n, bus.drop_cnt, m_drop);
            end
`endif
            if (en_r) begin
                if ($urandom_range(0, 59) == 0) en_r = 1'b0;
            end else begin
                if ($urandom_range(0, 7) == 0) en_r = 1'b1;
            end
            bus.en = en_r;
            rst = ($urandom_range(0, 499) == 0);
            bus.req_miss = ($urandom_range(0, 9) == 0);
            bus.req_bounce = ($urandom_range(0, 9) == 0);
            bus.req_hit = ($urandom_range(0, 9) == 0);
        end
        rst = 1'b0;
        bus.en = 1'b1;
        clear_reqs();
        next_cycle();
    endtask

    initial begin
        bus.en = 1'b1;
        clear_reqs();
        test_reset();
        test_single();
        test_priority();
        test_dup_drop();
        test_collision();
        test_reset_mid_hold();
        test_enable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/audio_sound_arbiter.md
AUDIO_SOUND_ARBITER -- requirements
Module: audio_sound_arbiter

Interface
REQ-001 SHALL have parameter CLKS_PER_MS, default 16000: clock cycles per millisecond, legal range 2..65535.
REQ-002 SHALL have parameter HOLD_MS_MISS, default 70: guard time after a miss sound, in ms, 8-bit.
REQ-003 SHALL have parameter HOLD_MS_BOUNCE, default 50: guard time after a bounce sound, in ms, 8-bit.
REQ-004 SHALL have parameter HOLD_MS_HIT, default 40: guard time after a hit sound, in ms, 8-bit.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: sound enable; when low, all new requests are discarded.
REQ-008 SHALL have ports req_miss, req_bounce and req_hit, each an input, 1 bit: single-cycle request pulses from game logic.
REQ-009 SHALL have port snd_sel, output, 2 bits: registered sound code to the audio driver; 0=none, 1=miss, 2=bounce, 3=hit.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE or any pending flag is set.

Function
REQ-011 SHALL keep one sticky pending flag per sound, set by its req_* pulse while en=1.
REQ-012 SHALL implement FSM IDLE->ISSUE->HOLD->IDLE.
- IDLE: if any pending flag is set, go to ISSUE on the next cycle; otherwise stay in IDLE.
REQ-013 SHALL select by fixed priority miss > hit > bounce at the IDLE->ISSUE transition, and latch the selected code.
REQ-014 SHALL behave as follows in ISSUE, which lasts exactly 1 cycle:
- snd_sel equals the latched code for that cycle only; snd_sel=0 in every other state.
- clear the selected pending flag;
- load the hold counter with the HOLD_MS value for that sound;
- restart the ms prescaler at 0.
REQ-015 SHALL behave as follows in HOLD:
- the prescaler counts 0..CLKS_PER_MS-1 and emits a 1-cycle tick on its terminal count;
- the hold counter decrements on each tick;
- the FSM goes to IDLE on the tick that takes the counter to 0, so HOLD lasts exactly HOLD_MS*CLKS_PER_MS cycles.
REQ-016 SHALL treat a HOLD_MS parameter of 0 as 1.
REQ-017 SHALL define the spacing between ISSUE cycles of back-to-back sounds as exactly HOLD_MS*CLKS_PER_MS + 2 cycles.
REQ-018 SHALL drop, and never queue twice, a request whose pending flag is already set.
REQ-019 SHALL drop a request for the sound being issued that arrives in the ISSUE cycle itself (clear wins).
REQ-020 SHALL capture, without loss and ahead of clearing, a request for a different sound that arrives in the ISSUE cycle.
REQ-021 SHALL capture all simultaneous requests as pending and serve them in priority order.
REQ-022 SHALL, when en falls, clear all pending flags in that cycle, let the current ISSUE/HOLD complete, and then remain in IDLE.
REQ-023 SHALL never produce a nonzero snd_sel value outside ISSUE, including on the cycle after reset.

Reset
REQ-024 SHALL, when rst=1 (including mid-HOLD), set on the next edge:
- state=IDLE;
- all pending flags=0;
- snd_sel=0 and busy=0;
- prescaler=0 and hold counter=0;
- drop count=0 (if built).
REQ-025 SHALL ignore requests in any cycle where rst=1.

Configuration
REQ-026 SHALL, with macro AUDIO_ARB_DROPCNT_EN defined, add output drop_cnt, 8 bits.
- drop_cnt increments once per cycle in which at least one request is dropped under REQ-018 or REQ-019, or discarded by en=0.
- drop_cnt saturates at 255.
REQ-027 SHALL, without AUDIO_ARB_DROPCNT_EN, omit the drop_cnt port and its logic; all other behaviour is identical.

Structure
REQ-028 SHALL take from shared package audio_pkg:
- sound codes SND_NONE, SND_MISS, SND_BOUNCE, SND_HIT;
- the FSM state encoding ARB_IDLE, ARB_ISSUE, ARB_HOLD.
REQ-029 SHALL place the ms prescaler in sub-module audio_ms_tick, with inputs clk, rst and restart, output tick, and parameter CLKS_PER_MS.

Verification (bench uses CLKS_PER_MS=4, HOLD_MS_MISS=3, HOLD_MS_BOUNCE=2, HOLD_MS_HIT=1)
REQ-030 SHALL verify a single request: req_bounce pulse at cycle 10 -> snd_sel=2 at cycle 12 only; busy falls at cycle 21.
REQ-031 SHALL verify priority: req_bounce, req_hit and req_miss pulsed together -> snd_sel sequence 1, 3, 2, with ISSUE cycles spaced 14 and 6 cycles apart.
REQ-032 SHALL verify duplicate drop: two req_hit pulses during a miss HOLD -> exactly one hit issued; drop_cnt=1 with AUDIO_ARB_DROPCNT_EN.
REQ-033 SHALL verify ISSUE-cycle collision: req_miss in the miss ISSUE cycle is dropped, while req_hit in the same cycle is issued afterwards.
REQ-034 SHALL verify reset mid-HOLD: rst pulsed 5 cycles into a miss HOLD -> snd_sel=0 and busy=0 the next cycle; a new req_hit then issues 2 cycles after its pulse.
REQ-035 SHALL verify enable: en=0 with pending bounce and hit -> both cleared, no snd_sel activity, drop_cnt increments per dropped-request cycle.
